// File: rtl/sr_flip_flop_pkg.sv
// rtl/sr_flip_flop_pkg.sv - invalid-input modes and per-bit SR next-state rule
package sr_flip_flop_pkg;

   typedef enum logic [1:0] {
      SR_HOLD    = 2'd0,
      SR_SET_DOM = 2'd1,
      SR_RST_DOM = 2'd2,
      SR_TOGGLE  = 2'd3
   } sr_mode_e;

   function automatic logic sr_next(input logic q, input logic s, input logic r,
                                    input sr_mode_e mode);
      logic nxt;
      nxt = q;
      case ({s, r})
         2'b10: nxt = 1'b1;
         2'b01: nxt = 1'b0;
         2'b11: begin
            case (mode)
               SR_SET_DOM: nxt = 1'b1;
               SR_RST_DOM: nxt = 1'b0;
               SR_TOGGLE:  nxt = ~q;
               default:    nxt = q;
            endcase
         end
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// rtl/sr_ff_cell.sv - single SR storage bit; SR_FF_INVALID_FLAG_EN adds the invalid-input flag
module sr_ff_cell
   import sr_flip_flop_pkg::*;
#(
   parameter sr_mode_e MODE      = SR_HOLD,
   parameter logic     RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic s,
   input  logic r,
   output logic q,
   output logic q_not
`ifdef SR_FF_INVALID_FLAG_EN
   ,
   output logic invalid
`endif
);

   logic q_reg;

   always_ff @(posedge clk) begin
      if (rst) q_reg <= RESET_BIT;
      else     q_reg <= sr_next(q_reg, s, r, MODE);
   end

   // Both outputs come from one flop so they can never agree.
   assign q     = q_reg;
   assign q_not = ~q_reg;

`ifdef SR_FF_INVALID_FLAG_EN
   logic invalid_reg;

   always_ff @(posedge clk) begin
      if (rst) invalid_reg <= 1'b0;
      else     invalid_reg <= s & r;
   end

   assign invalid = invalid_reg;
`endif

endmodule

// File: rtl/sr_flip_flop.sv
// rtl/sr_flip_flop.sv - WIDTH-bit clocked SR flip-flop bank; SR_FF_INVALID_FLAG_EN adds invalid/invalid_seen
module sr_flip_flop
   import sr_flip_flop_pkg::*;
#(
   parameter int               WIDTH        = 1,
   parameter int               INVALID_MODE = 0,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] S,
   input  logic [WIDTH-1:0] R,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_not
`ifdef SR_FF_INVALID_FLAG_EN
   ,
   output logic [WIDTH-1:0] invalid,
   output logic             invalid_seen
`endif
);

   // Out-of-range mode values fall back to hold.
   localparam sr_mode_e MODE = (INVALID_MODE >= 0 && INVALID_MODE <= 3)
                               ? sr_mode_e'(INVALID_MODE[1:0]) : SR_HOLD;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sr_ff_cell #(
         .MODE      (MODE),
         .RESET_BIT (RESET_VALUE[i])
      ) u_cell (
         .clk     (clk),
         .rst     (rst),
         .s       (S[i]),
         .r       (R[i]),
         .q       (Q[i]),
         .q_not   (Q_not[i])
`ifdef SR_FF_INVALID_FLAG_EN
         ,
         .invalid (invalid[i])
`endif
      );
   end

`ifdef SR_FF_INVALID_FLAG_EN
   logic seen_reg;

   always_ff @(posedge clk) begin
      if (rst) seen_reg <= 1'b0;
      else     seen_reg <= seen_reg | (|invalid);
   end

   assign invalid_seen = seen_reg;
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
// tb/tb_sr_flip_flop.sv - randomized self-checking bench for sr_flip_flop, all invalid modes
module tb_sr_flip_flop;

   localparam int NDUT = 5;
   localparam int MODES [NDUT] = '{0, 1, 2, 3, 7};
   localparam logic [3:0] RV [NDUT] = '{4'b0000, 4'b0000, 4'b0110, 4'b1001, 4'b0000};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] S = '0;
   logic [3:0] R = '0;
   logic [3:0] q_o  [NDUT];
   logic [3:0] qn_o [NDUT];
`ifdef SR_FF_INVALID_FLAG_EN
   logic [3:0] inv_o  [NDUT];
   logic       seen_o [NDUT];
`endif

   int checks   = 0;
   int failures = 0;

   logic [3:0] model [NDUT];
   logic [3:0] inv_m;
   logic       seen_m;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      sr_flip_flop #(
         .WIDTH        (4),
         .INVALID_MODE (MODES[g]),
         .RESET_VALUE  (RV[g])
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .S            (S),
         .R            (R),
         .Q            (q_o[g]),
         .Q_not        (qn_o[g])
`ifdef SR_FF_INVALID_FLAG_EN
         ,
         .invalid      (inv_o[g]),
         .invalid_seen (seen_o[g])
`endif
      );
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Behavioural rule table: what one bit becomes given the truth table and mode.
   function automatic logic [3:0] ref_next(input logic [3:0] q, input logic [3:0] s,
                                           input logic [3:0] r, input int mode,
                                           input logic [3:0] rv, input logic rs);
      logic [3:0] n;
      if (rs) return rv;
      for (int b = 0; b < 4; b++) begin
         if (s[b] && !r[b])      n[b] = 1'b1;
         else if (!s[b] && r[b]) n[b] = 1'b0;
         else if (s[b] && r[b]) begin
            if (mode == 1)      n[b] = 1'b1;
            else if (mode == 2) n[b] = 1'b0;
            else if (mode == 3) n[b] = !q[b];
            else                n[b] = q[b];
         end
         else n[b] = q[b];
      end
      return n;
   endfunction

   task automatic check_all(input string tag);
      for (int k = 0; k < NDUT; k++) begin
         check_val($sformatf("%s_q%0d", tag, k), {28'd0, q_o[k]}, {28'd0, model[k]});
         check_val($sformatf("%s_qn%0d", tag, k), {28'd0, qn_o[k]}, {28'd0, ~model[k]});
`ifdef SR_FF_INVALID_FLAG_EN
         check_val($sformatf("%s_inv%0d", tag, k), {28'd0, inv_o[k]}, {28'd0, inv_m});
         check_val($sformatf("%s_seen%0d", tag, k), {31'd0, seen_o[k]}, {31'd0, seen_m});
`endif
      end
   endtask

   task automatic step(input string tag, input logic rs, input logic [3:0] s_in,
                       input logic [3:0] r_in);
      rst = rs;
      S   = s_in;
      R   = r_in;
      @(posedge clk);
      for (int k = 0; k < NDUT; k++)
         model[k] = ref_next(model[k], s_in, r_in, MODES[k], RV[k], rs);
      seen_m = rs ? 1'b0 : (seen_m | (|inv_m));
      inv_m  = rs ? 4'b0000 : (s_in & r_in);
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      for (int k = 0; k < NDUT; k++) model[k] = '0;
      inv_m  = '0;
      seen_m = 1'b0;
      @(negedge clk);

      step("rst", 1'b1, 4'h0, 4'h0);
      step("idle1", 1'b0, 4'h0, 4'h0);
      step("idle2", 1'b0, 4'h0, 4'h0);
      step("set", 1'b0, 4'hF, 4'h0);
      step("hold1", 1'b0, 4'h0, 4'h0);
      step("clr", 1'b0, 4'h0, 4'hF);
      step("inv_from0", 1'b0, 4'hF, 4'hF);
      step("inv_next", 1'b0, 4'h0, 4'h0);
      step("set2", 1'b0, 4'hF, 4'h0);
      step("inv_from1", 1'b0, 4'hF, 4'hF);
      step("rst_vs_set", 1'b1, 4'hF, 4'h0);
      step("ld1010", 1'b0, 4'b1010, 4'b0000);
      step("mix", 1'b0, 4'b0101, 4'b0011);
      check_val("mix_const_q0", {28'd0, q_o[0]}, 32'hC);

      for (int n = 0; n < 300; n++)
         step("rand", ($urandom_range(15) == 0), 4'($urandom), 4'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
